// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    // HI/LO write source codes; this block produces the MUL and DIV sources
    typedef enum logic [1:0] {
        HILO_SRC_ALU = 2'b00,
        HILO_SRC_MUL = 2'b01,
        HILO_SRC_DIV = 2'b10
    } hilo_src_e;

    // Quotient reported on a zero divisor
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Magnitude of v, treating it as two's complement only when sgn is set
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake and operand bus between the EX-stage decoder/datapath and muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        start;
    logic        is_div;
    logic        sign;
    logic        annul;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        stall;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start, is_div, sign, annul, opa, opb,
        input  stall, busy, done, hilo_we, hi_o, lo_o
    );

    modport slave (
        input  start, is_div, sign, annul, opa, opb,
        output stall, busy, done, hilo_we, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl_div_core.sv
// Iterative restoring divider: one quotient bit per step, sign fix-up on the outputs.
module muldiv_ctrl_div_core
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_sign,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_q,
    output logic [31:0] o_r,
    output logic        o_last
);

    localparam logic [5:0] LAST_CNT = 6'(DIV_ITERS - 1);

    // Upper half is the partial remainder; lower half shifts dividend bits out
    // and quotient bits in.
    logic [63:0] r_rem;
    logic [31:0] r_dsr;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [5:0]  r_cnt;

    logic [32:0] w_sh_hi;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [63:0] w_rem_next;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    // One shift-subtract step; 33-bit compare keeps large unsigned divisors exact.
    // Outputs reflect the step in progress so the final result is capturable
    // on the same edge that completes it.
    always_comb begin
        w_sh_hi    = r_rem[63:31];
        w_diff     = w_sh_hi - {1'b0, r_dsr};
        w_ge       = ~w_diff[32];
        w_rem_next = {(w_ge ? w_diff[31:0] : w_sh_hi[31:0]), r_rem[30:0], w_ge};
        w_q_mag    = w_rem_next[31:0];
        w_r_mag    = w_rem_next[63:32];
        o_q        = r_div_zero ? DIV_ZERO_Q : (r_neg_q ? -w_q_mag : w_q_mag);
        o_r        = r_neg_r ? -w_r_mag : w_r_mag;
        o_last     = (r_cnt == LAST_CNT);
    end

    // Operand setup on load, one iteration per step
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem      <= '0;
            r_dsr      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
        end else if (i_load) begin
            r_rem      <= {32'h0, abs32(i_dividend, i_sign)};
            r_dsr      <= abs32(i_divisor, i_sign);
            r_neg_q    <= i_sign & (i_dividend[31] ^ i_divisor[31]);
            r_neg_r    <= i_sign & i_dividend[31];
            r_div_zero <= (i_divisor == 32'h0);
            r_cnt      <= '0;
        end else if (i_step) begin
            r_rem      <= w_rem_next;
            r_cnt      <= r_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: FSM, stall/annul, multiplier and HI/LO results.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_ITERS   = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);

    md_state_e   r_state;
    md_state_e   w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_a_mag;
    logic [31:0] r_b_mag;
    logic        r_neg_p;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_stall;
    logic        w_div_step;
    logic        w_mul_fin;
    logic        w_div_fin;
    logic        w_div_last;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;

    assign w_accept = (r_state == MD_IDLE) & bus.start & ~bus.annul;

    // Next state, stall and completion strobes; annul aborts MUL/DIV at once
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_div_step   = 1'b0;
        w_mul_fin    = 1'b0;
        w_div_fin    = 1'b0;
        unique case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    w_stall      = 1'b1;
                    w_state_next = bus.is_div ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL: begin
                if (bus.annul) begin
                    w_state_next = MD_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == MUL_LAST) begin
                        w_state_next = MD_DONE;
                        w_mul_fin    = 1'b1;
                    end
                end
            end
            MD_DIV: begin
                if (bus.annul) begin
                    w_state_next = MD_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_div_step = 1'b1;
                    if (w_div_last) begin
                        w_state_next = MD_DONE;
                        w_div_fin    = 1'b1;
                    end
                end
            end
            MD_DONE: w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    // Magnitude product, sign applied afterwards
    always_comb begin
        w_prod_mag = {32'h0, r_a_mag} * {32'h0, r_b_mag};
        w_prod     = r_neg_p ? -w_prod_mag : w_prod_mag;
    end

    // State, multiplier latency counter and latched multiply operands
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_a_mag <= '0;
            r_b_mag <= '0;
            r_neg_p <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (r_state == MD_MUL) ? r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_a_mag <= abs32(bus.opa, bus.sign);
                r_b_mag <= abs32(bus.opb, bus.sign);
                r_neg_p <= bus.sign & (bus.opa[31] ^ bus.opb[31]);
            end
        end
    end

    // HI/LO result registers; loaded only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_mul_fin) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
        end else if (w_div_fin) begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
        end
    end

    muldiv_ctrl_div_core #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept & bus.is_div),
        .i_step     (w_div_step),
        .i_sign     (bus.sign),
        .i_dividend (bus.opa),
        .i_divisor  (bus.opb),
        .o_q        (w_div_q),
        .o_r        (w_div_r),
        .o_last     (w_div_last)
    );

    assign bus.stall   = w_stall;
    assign bus.busy    = (r_state == MD_MUL) | (r_state == MD_DIV);
    assign bus.done    = (r_state == MD_DONE);
    assign bus.hilo_we = (r_state == MD_DONE);
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, corner sequences, random ops.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int ITERS   = 32;

    typedef struct {
        logic        is_div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_ctrl_if u_if ();

    muldiv_ctrl #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_ITERS   (ITERS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;
    vec_t        vecs[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference results from plain arithmetic
    function automatic void model(input logic div, input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo);
        logic [63:0] p;
        if (!div) begin
            if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else     p = {32'h0, a} * {32'h0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sgn) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'h0;
        end else begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
        end
    endfunction

    // Runs one operation starting at the current negedge (cycle 0). annul_cyc < 0 means
    // no annul. Ends at the negedge after the last checked cycle, so a following call
    // starts in the cycle right after DONE.
    task automatic do_op(input string tag, input logic div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int annul_cyc, input bit start_in_done);
        int d;
        bit aborted;
        int lim;
        logic e_stall;
        logic e_busy;
        logic e_done;
        d       = div ? ITERS + 1 : MUL_LAT + 1;
        aborted = (annul_cyc >= 0) && (annul_cyc < d);
        lim     = aborted ? 40 : d;
        u_if.is_div = div;
        u_if.sign   = sgn;
        u_if.opa    = a;
        u_if.opb    = b;
        for (int c = 0; c <= lim; c++) begin
            u_if.start = (c == 0) || (start_in_done && c == d);
            u_if.annul = (c == annul_cyc);
            if (c == 1) begin
                // operands must have been latched at cycle 0
                u_if.opa  = ~a;
                u_if.opb  = ~b;
                u_if.sign = ~sgn;
            end
            #1;
            if (aborted && c >= annul_cyc) begin
                e_stall = 1'b0;
                e_busy  = (c == annul_cyc) && (c > 0);
                e_done  = 1'b0;
            end else begin
                e_stall = (c < d);
                e_busy  = (c > 0) && (c < d);
                e_done  = (c == d);
            end
            chk($sformatf("%s c%0d stall", tag, c), 32'(u_if.stall), 32'(e_stall));
            chk($sformatf("%s c%0d busy", tag, c), 32'(u_if.busy), 32'(e_busy));
            chk($sformatf("%s c%0d done", tag, c), 32'(u_if.done), 32'(e_done));
            chk($sformatf("%s c%0d hilo_we", tag, c), 32'(u_if.hilo_we), 32'(e_done));
            if (!aborted && c == d - 1) begin
                chk($sformatf("%s c%0d hi hold", tag, c), u_if.hi_o, exp_hi);
                chk($sformatf("%s c%0d lo hold", tag, c), u_if.lo_o, exp_lo);
            end
            if (!aborted && c == d) begin
                chk($sformatf("%s hi", tag), u_if.hi_o, ehi);
                chk($sformatf("%s lo", tag), u_if.lo_o, elo);
                exp_hi = ehi;
                exp_lo = elo;
            end
            if (aborted && c == lim) begin
                chk($sformatf("%s hi kept", tag), u_if.hi_o, exp_hi);
                chk($sformatf("%s lo kept", tag), u_if.lo_o, exp_lo);
            end
            @(negedge clk);
        end
        u_if.start = 1'b0;
        u_if.annul = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        #1;
        chk({tag, " idle stall"}, 32'(u_if.stall), 32'h0);
        chk({tag, " idle busy"}, 32'(u_if.busy), 32'h0);
        chk({tag, " idle done"}, 32'(u_if.done), 32'h0);
        @(negedge clk);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, " stall"}, 32'(u_if.stall), 32'h0);
        chk({tag, " busy"}, 32'(u_if.busy), 32'h0);
        chk({tag, " done"}, 32'(u_if.done), 32'h0);
        chk({tag, " hilo_we"}, 32'(u_if.hilo_we), 32'h0);
        chk({tag, " hi"}, u_if.hi_o, 32'h0);
        chk({tag, " lo"}, u_if.lo_o, 32'h0);
    endtask

    initial begin
        logic        r_div;
        logic        r_sgn;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        int          r_annul;

        vecs[0] = '{1'b1, 1'b0, 32'd7, 32'd2, 32'h1, 32'h3};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
        vecs[4] = '{1'b1, 1'b0, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD};
        vecs[8] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4};

        u_if.start  = 1'b0;
        u_if.is_div = 1'b0;
        u_if.sign   = 1'b0;
        u_if.annul  = 1'b0;
        u_if.opa    = 32'h0;
        u_if.opb    = 32'h0;
        rst         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        zero_check("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back to back
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].sgn, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, -1, 1'b0);
        end
        idle_check("vec_end");

        // Annul mid-DIV, mid-MUL, and together with start
        do_op("annul_div10", 1'b1, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 10, 1'b0);
        do_op("annul_mul1", 1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0, 1, 1'b0);
        do_op("annul_start", 1'b1, 1'b0, 32'd9, 32'd3, 32'h0, 32'h0, 0, 1'b0);

        // Annul during DONE still writes; start during DONE is ignored
        do_op("annul_done", 1'b0, 1'b0, 32'd3, 32'd5, 32'h0, 32'd15, MUL_LAT + 1, 1'b0);
        do_op("start_done", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2,
              -1, 1'b1);
        idle_check("start_done");

        // Reset in cycle 15 of a DIV
        u_if.is_div = 1'b1;
        u_if.sign   = 1'b0;
        u_if.opa    = 32'd1000;
        u_if.opb    = 32'd3;
        for (int c = 0; c <= 15; c++) begin
            u_if.start = (c == 0);
            rst        = (c != 15);
            @(negedge clk);
        end
        u_if.start = 1'b0;
        rst        = 1'b1;
        #1;
        zero_check("mid_reset");
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        @(negedge clk);
        do_op("post_reset_mul", 1'b0, 1'b1, 32'd3, 32'd4, 32'h0, 32'hC, -1, 1'b0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            r_div = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'h0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            r_annul = -1;
            if ($urandom_range(0, 7) == 0) begin
                r_annul = $urandom_range(1, r_div ? ITERS : MUL_LAT);
            end
            model(r_div, r_sgn, r_a, r_b, m_hi, m_lo);
            do_op($sformatf("rnd%0d", i), r_div, r_sgn, r_a, r_b, m_hi, m_lo, r_annul, 1'b0);
        end
        idle_check("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage of the MIPS pipeline. It accepts a start pulse, operation select and sign flag from the main decoder/datapath, and runs either a fixed-latency multiplier or a 32-iteration shift-subtract divider. It holds the pipeline with a stall while busy, then presents one HI/LO write. An annul input aborts the operation in flight when EX is flushed.

Parameters:
MUL_LATENCY, 2, cycles the multiplier stays in MUL state before DONE (legal range 1..15)
DIV_ITERS, 32, divider iterations (fixed at 32 for 32-bit operands; the parameter exists for bench speed-up only)

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin an operation; sampled only in IDLE
is_div  in  1  1 = DIV/DIVU, 0 = MULT/MULTU
sign  in  1  1 = signed operands
annul  in  1  abort the current operation (EX flush)
opa  in  32  rs value (dividend / multiplicand)
opb  in  32  rt value (divisor / multiplier)
stall  out  1  hold IF/ID/EX
busy  out  1  state is neither IDLE nor DONE
done  out  1  one-cycle result-valid strobe
hilo_we  out  1  write HI and LO this cycle (equals done)
hi_o  out  32  HI result (remainder, or product[63:32])
lo_o  out  32  LO result (quotient, or product[31:0])

Behaviour:
- Reset (rst=0 at an edge): state IDLE. stall, busy, done and hilo_we = 0; hi_o and lo_o = 0; iteration counter = 0. Reset wins over every other input, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start=1 and annul=0, latch opa, opb, sign and is_div at the edge.
  - Next state is DIV (is_div=1) or MUL (is_div=0). Counter is cleared.
  - If start=1 and annul=1, stay in IDLE.
- Cycle numbering: cycle 0 is the cycle in which start is sampled.
- stall = (IDLE & start & ~annul) | ((MUL | DIV) & ~annul). stall is combinational, so cycle 0 already stalls. stall = 0 in DONE.
- MUL:
  - Operand magnitudes are multiplied from the latched registers.
  - Counter increments each cycle. After MUL_LATENCY cycles in MUL, go to DONE.
  - done occurs in cycle MUL_LATENCY+1 (cycle 3 at the default).
  - Signed: product is negated when opa[31]^opb[31].
- DIV:
  - Setup on entry: absolute values of the operands when sign=1.
  - One restoring shift-subtract iteration per cycle, in cycles 1..DIV_ITERS. Then go to DONE.
  - done occurs in cycle 33.
  - Quotient is negated if the dividend and divisor signs differ. Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 32'h80000000, hi = 0 (natural truncation).
  - Divisor = 0: no exception. lo = 32'hFFFFFFFF, hi = opa (unsigned and signed alike). Latency unchanged.
- DONE:
  - done = hilo_we = 1 for exactly one cycle. hi_o/lo_o are valid.
  - Unconditional next state is IDLE. start in DONE is ignored.
  - hi_o/lo_o hold their last values until the next DONE.
- annul in MUL or DIV: stall drops in the same cycle; next state is IDLE; no hilo_we; hi_o/lo_o unchanged.
- annul in DONE: does not suppress the write. The instruction has already completed.
- Back-to-back: a start in the first cycle after DONE (IDLE) is accepted normally.

Decomposition:
- Shared package (defines.vh): state encodings MD_IDLE/MD_MUL/MD_DIV/MD_DONE; DIV_ZERO_Q = 32'hFFFFFFFF.
- The existing DataToHI/DataToLO codes (00 ALU, 01 mult, 10 div) stay in the package; this block is their producer.
- One sub-module: div_core. It is the iterative divider datapath: 64-bit partial remainder, quotient shift register, iteration counter and sign fix-up. It takes load/step inputs and returns q, r and last.
- muldiv_ctrl owns the FSM, the stall/annul logic, the multiplier and the output muxing.

Test Plan:
- DIVU 7/2: start at cycle 0 -> stall=1 for cycles 0..32; cycle 33 done=1, hilo_we=1, lo=1'h...: lo=32'h3, hi=32'h1; cycle 34 IDLE, stall=0.
- DIV signed -7/2 (opa=32'hFFFFFFF9, opb=2) -> cycle 33: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- MULTU then MULT with opa=opb=32'hFFFFFFFF:
  - MULTU -> cycle 3: hi=32'hFFFFFFFE, lo=32'h00000001.
  - MULT -> hi=32'h0, lo=32'h1.
- DIVU 5/0 -> cycle 33: lo=32'hFFFFFFFF, hi=32'h5. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIV started, annul=1 in cycle 10 -> stall=0 in cycle 10; IDLE at cycle 11; no done/hilo_we through cycle 40; prior hi_o/lo_o retained.
- rst=0 in cycle 15 of a DIV -> all outputs 0 next cycle. A subsequent MULT 3*4 completes with lo=32'hC, hi=0 at cycle 3.
